// File: rtl/obstacle_follower.sv
// Single falling obstacle: scrolls down on move_followers, bounces horizontally on its own
// tick counter, respawns at the top with an LFSR-chosen column, and flags player collisions.
module obstacle_follower #(
  parameter int          SCREEN_WIDTH  = 640,
  parameter int          SCREEN_HEIGHT = 480,
  parameter int          MOVE_AMT      = 2,
  parameter int          OBS_W         = 32,
  parameter int          OBS_H         = 16,
  parameter int          PLAYER_W      = 16,
  parameter int          PLAYER_H      = 16,
  parameter int          INIT_X        = 304,
  parameter int          INIT_Y        = 0,
  parameter int          H_SPEED       = 50000,
  parameter int          H_STEP        = 1,
  parameter logic [7:0]  SEED          = 8'hA5
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       move_followers_i,
  input  logic [9:0] player_x_i,
  input  logic [9:0] player_y_i,
  input  logic [9:0] hpos_i,
  input  logic [9:0] vpos_i,
  output logic [9:0] obs_x_o,
  output logic [9:0] obs_y_o,
  output logic       obs_dir_o,
  output logic       respawn_o,
  output logic       obs_on_o,
  output logic       hit_o
);

  localparam int               HW    = (H_SPEED > 2) ? $clog2(H_SPEED) : 1;
  localparam logic [HW-1:0]    HMAX  = HW'(H_SPEED - 1);
  localparam logic [10:0]      XMAX  = 11'(SCREEN_WIDTH - OBS_W);

  logic [9:0]    obs_x_q, obs_x_d;
  logic [9:0]    obs_y_q, obs_y_d;
  logic          obs_dir_q, obs_dir_d;
  logic          respawn_q, respawn_d;
  logic          obs_on_q, obs_on_d;
  logic          hit_q, hit_d;
  logic [HW-1:0] hctr_q, hctr_d;
  logic [7:0]    lfsr_q, lfsr_d;

  logic [7:0]    lfsr_next;
  logic          h_tick;
  logic          wrap;
  logic          overlap;
  logic [10:0]   obs_x_w, obs_y_w, player_x_w, player_y_w, hpos_w, vpos_w;

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      obs_x_q   <= 10'(INIT_X);
      obs_y_q   <= 10'(INIT_Y);
      obs_dir_q <= 1'b0;
      respawn_q <= 1'b0;
      obs_on_q  <= 1'b0;
      hit_q     <= 1'b0;
      hctr_q    <= '0;
      lfsr_q    <= SEED;
    end else begin
      obs_x_q   <= obs_x_d;
      obs_y_q   <= obs_y_d;
      obs_dir_q <= obs_dir_d;
      respawn_q <= respawn_d;
      obs_on_q  <= obs_on_d;
      hit_q     <= hit_d;
      hctr_q    <= hctr_d;
      lfsr_q    <= lfsr_d;
    end
  end

  // All box tests are done one bit wider so that right/bottom edges never overflow.
  assign obs_x_w    = {1'b0, obs_x_q};
  assign obs_y_w    = {1'b0, obs_y_q};
  assign player_x_w = {1'b0, player_x_i};
  assign player_y_w = {1'b0, player_y_i};
  assign hpos_w     = {1'b0, hpos_i};
  assign vpos_w     = {1'b0, vpos_i};

  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign h_tick    = (hctr_q == HMAX);
  assign wrap      = (obs_y_w + 11'(MOVE_AMT)) >= 11'(SCREEN_HEIGHT);
  assign overlap   = (player_x_w < obs_x_w + 11'(OBS_W)) && (obs_x_w < player_x_w + 11'(PLAYER_W)) &&
                     (player_y_w < obs_y_w + 11'(OBS_H)) && (obs_y_w < player_y_w + 11'(PLAYER_H));

  // Motion is frozen once the player has been hit; respawn takes priority over the bounce.
  always_comb begin
    obs_x_d   = obs_x_q;
    obs_y_d   = obs_y_q;
    obs_dir_d = obs_dir_q;
    respawn_d = 1'b0;
    hctr_d    = hctr_q;
    lfsr_d    = lfsr_q;
    obs_on_d  = (hpos_w >= obs_x_w) && (hpos_w < obs_x_w + 11'(OBS_W)) &&
                (vpos_w >= obs_y_w) && (vpos_w < obs_y_w + 11'(OBS_H));
    hit_d     = hit_q | overlap;
    if (!hit_q) begin
      hctr_d = h_tick ? '0 : hctr_q + 1'b1;
      if (h_tick) begin
        if (!obs_dir_q) begin
          if (obs_x_w + 11'(H_STEP) > XMAX) begin
            obs_x_d   = XMAX[9:0];
            obs_dir_d = 1'b1;
          end else begin
            obs_x_d = obs_x_q + 10'(H_STEP);
          end
        end else begin
          if (obs_x_w < 11'(H_STEP)) begin
            obs_x_d   = '0;
            obs_dir_d = 1'b0;
          end else begin
            obs_x_d = obs_x_q - 10'(H_STEP);
          end
        end
      end
      if (move_followers_i) begin
        if (wrap) begin
          obs_y_d   = '0;
          lfsr_d    = lfsr_next;
          obs_x_d   = {1'b0, lfsr_next, 1'b0};
          obs_dir_d = lfsr_next[0];
          respawn_d = 1'b1;
        end else begin
          obs_y_d = obs_y_q + 10'(MOVE_AMT);
        end
      end
    end
  end

  assign obs_x_o   = obs_x_q;
  assign obs_y_o   = obs_y_q;
  assign obs_dir_o = obs_dir_q;
  assign respawn_o = respawn_q;
  assign obs_on_o  = obs_on_q;
  assign hit_o     = hit_q;

endmodule

// File: tb/tb_obstacle_follower.sv
// Directed bench for obstacle_follower: instance A uses the real horizontal speed,
// instance B a 4-cycle tick so the bounce and reset-versus-tick cases are reachable.
module tb_obstacle_follower;

  logic       clk = 1'b0;
  logic       reset;
  logic       moveFollowers;
  logic [9:0] playerX, playerY, hpos, vpos;

  logic [9:0] aObsX, aObsY, bObsX, bObsY;
  logic       aDir, aRespawn, aObsOn, aHit;
  logic       bDir, bRespawn, bObsOn, bHit;

  int assertCount = 0;
  int failCount   = 0;
  bit found;

  always #5 clk = ~clk;

  obstacle_follower dutA (
    .clk_i(clk), .reset_i(reset), .move_followers_i(moveFollowers),
    .player_x_i(playerX), .player_y_i(playerY), .hpos_i(hpos), .vpos_i(vpos),
    .obs_x_o(aObsX), .obs_y_o(aObsY), .obs_dir_o(aDir), .respawn_o(aRespawn),
    .obs_on_o(aObsOn), .hit_o(aHit)
  );

  obstacle_follower #(.H_SPEED(4)) dutB (
    .clk_i(clk), .reset_i(reset), .move_followers_i(moveFollowers),
    .player_x_i(playerX), .player_y_i(playerY), .hpos_i(hpos), .vpos_i(vpos),
    .obs_x_o(bObsX), .obs_y_o(bObsY), .obs_dir_o(bDir), .respawn_o(bRespawn),
    .obs_on_o(bObsOn), .hit_o(bHit)
  );

  // One clock edge; inputs change and outputs are sampled on the falling edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    applyStimulus(2);
    reset = 1'b1;
  endtask

  typedef struct { logic [9:0] h; logic [9:0] v; logic exp; } onVec_t;
  onVec_t onVecs[5] = '{
    '{10'd304, 10'd0,  1'b1},
    '{10'd303, 10'd0,  1'b0},
    '{10'd335, 10'd15, 1'b1},
    '{10'd336, 10'd15, 1'b0},
    '{10'd320, 10'd16, 1'b0}
  };

  typedef struct { logic [9:0] x; logic [9:0] y; } pVec_t;
  pVec_t touchVecs[3] = '{ '{10'd336, 10'd2}, '{10'd288, 10'd2}, '{10'd304, 10'd16} };

  initial begin
    moveFollowers = 1'b0;
    playerX = 10'd0;
    playerY = 10'd400;
    hpos = 10'd0;
    vpos = 10'd0;
    @(negedge clk);

    // T1 reset values
    doReset();
    checkOutput("t1_x", aObsX, 304);
    checkOutput("t1_y", aObsY, 0);
    checkOutput("t1_dir", aDir, 0);
    checkOutput("t1_hit", aHit, 0);
    checkOutput("t1_respawn", aRespawn, 0);
    checkOutput("t1_obs_on", aObsOn, 0);

    // Pixel coverage edges around the obstacle at (304,0)
    foreach (onVecs[i]) begin
      hpos = onVecs[i].h;
      vpos = onVecs[i].v;
      applyStimulus(1);
      checkOutput($sformatf("obs_on_%0d", i), aObsOn, onVecs[i].exp);
    end
    hpos = 10'd0;
    vpos = 10'd0;

    // T2 three strobes
    moveFollowers = 1'b1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1);
      checkOutput($sformatf("t2_respawn_%0d", i), aRespawn, 0);
    end
    checkOutput("t2_y", aObsY, 6);

    // T3 drive to row 478 then wrap
    applyStimulus(236);
    checkOutput("t3_y478", aObsY, 478);
    applyStimulus(1);
    moveFollowers = 1'b0;
    checkOutput("t3_y", aObsY, 0);
    checkOutput("t3_respawn", aRespawn, 1);
    checkOutput("t3_x", aObsX, 148);
    checkOutput("t3_dir", aDir, 0);
    applyStimulus(1);
    checkOutput("t3_respawn_off", aRespawn, 0);
    checkOutput("t3_y_hold", aObsY, 0);

    // Touching boxes are not a collision
    doReset();
    foreach (touchVecs[i]) begin
      playerX = touchVecs[i].x;
      playerY = touchVecs[i].y;
      applyStimulus(1);
      checkOutput($sformatf("touch_hit_%0d", i), aHit, 0);
    end

    // T5 overlap sets hit, motion freezes, hit is sticky
    playerX = 10'd310;
    playerY = 10'd2;
    applyStimulus(1);
    checkOutput("t5_hit", aHit, 1);
    playerX = 10'd0;
    playerY = 10'd400;
    moveFollowers = 1'b1;
    applyStimulus(5);
    moveFollowers = 1'b0;
    checkOutput("t5_x", aObsX, 304);
    checkOutput("t5_y", aObsY, 0);
    checkOutput("t5_hit_sticky", aHit, 1);

    // T4 bounce at the right edge (instance B)
    doReset();
    found = 1'b0;
    for (int i = 0; i < 1400 && !found; i++) begin
      if (bObsX == 10'd607) found = 1'b1;
      else applyStimulus(1);
    end
    checkOutput("t4_reach607", {31'd0, found}, 1);
    applyStimulus(4);
    checkOutput("t4_x608", bObsX, 608);
    checkOutput("t4_dir0", bDir, 0);
    applyStimulus(4);
    checkOutput("t4_x608b", bObsX, 608);
    checkOutput("t4_dir1", bDir, 1);
    applyStimulus(4);
    checkOutput("t4_x607", bObsX, 607);
    checkOutput("t4_dir1b", bDir, 1);

    // T6 reset on the same edge as a strobe and an h-tick
    applyStimulus(3);
    reset = 1'b0;
    moveFollowers = 1'b1;
    applyStimulus(1);
    reset = 1'b1;
    checkOutput("t6_x", bObsX, 304);
    checkOutput("t6_y", bObsY, 0);
    checkOutput("t6_dir", bDir, 0);
    checkOutput("t6_respawn", bRespawn, 0);
    checkOutput("t6_hit", bHit, 0);
    checkOutput("t6_obs_on", bObsOn, 0);
    applyStimulus(239);
    checkOutput("t6_y478", bObsY, 478);
    applyStimulus(1);
    moveFollowers = 1'b0;
    checkOutput("t6_respawn_pulse", bRespawn, 1);
    checkOutput("t6_lfsr_x", bObsX, 148);
    checkOutput("t6_lfsr_dir", bDir, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
